// File: rtl/mul_share_rr_ctrl.sv
// Round-robin front end that shares one pipelined 14x5 multiplier among NUM_REQ requesters.
// Each issued operation's requester id travels in a tag pipeline aligned to the multiplier latency.
module mul_share_rr_ctrl #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int LAT     = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*14-1:0] req_a,
  input  logic [NUM_REQ*5-1:0]  req_b,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic                  mul_ce,
  output logic [13:0]           mul_din0,
  output logic [4:0]            mul_din1,
  input  logic [13:0]           mul_dout,
  output logic                  res_valid,
  output logic [13:0]           res_data,
  output logic [ID_W-1:0]       res_id,
  input  logic                  res_ready,
  output logic [2:0]            inflight
);

  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] ptr_nxt;
  logic [LAT-1:0]  tag_v;
  logic [LAT-1:0]  tag_v_nxt;
  logic [ID_W-1:0] tag_id [LAT];
  logic [2:0]      inflight_q;
  logic [2:0]      inflight_nxt;

  logic            grant_found;
  logic [ID_W-1:0] grant_idx;
  logic            hi_found;
  logic [ID_W-1:0] hi_idx;
  logic            lo_found;
  logic [ID_W-1:0] lo_idx;
  logic            stall;

  // Outputs are forced idle while reset is held so stale tags never show.
  assign res_valid = tag_v[LAT-1] && !reset;
  assign res_id    = tag_id[LAT-1];
  assign res_data  = mul_dout;
  assign inflight  = reset ? 3'd0 : inflight_q;

  assign stall  = res_valid && !res_ready;
  assign mul_ce = !reset && !stall;

  // Lowest requester at or above the pointer wins; otherwise wrap to the lowest overall.
  always_comb begin
    hi_found = 1'b0;
    hi_idx   = '0;
    lo_found = 1'b0;
    lo_idx   = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_valid[i]) begin
        lo_found = 1'b1;
        lo_idx   = ID_W'(i);
        if (i >= int'(rr_ptr)) begin
          hi_found = 1'b1;
          hi_idx   = ID_W'(i);
        end
      end
    end
    grant_found = hi_found || lo_found;
    grant_idx   = hi_found ? hi_idx : lo_idx;
  end

  always_comb begin
    req_ready = '0;
    mul_din0  = '0;
    mul_din1  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_found && grant_idx == ID_W'(i)) begin
        req_ready[i] = mul_ce;
        mul_din0     = req_a[14*i +: 14];
        mul_din1     = req_b[5*i +: 5];
      end
    end
  end

  always_comb begin
    ptr_nxt = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
  end

  always_comb begin
    tag_v_nxt    = {tag_v[LAT-2:0], grant_found};
    inflight_nxt = '0;
    for (int i = 0; i < LAT; i++) begin
      inflight_nxt = inflight_nxt + 3'(tag_v_nxt[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr     <= '0;
      tag_v      <= '0;
      inflight_q <= '0;
      for (int i = 0; i < LAT; i++) begin
        tag_id[i] <= '0;
      end
    end else if (mul_ce) begin
      tag_v      <= tag_v_nxt;
      inflight_q <= inflight_nxt;
      tag_id[0]  <= grant_idx;
      for (int i = 1; i < LAT; i++) begin
        tag_id[i] <= tag_id[i-1];
      end
      if (grant_found) begin
        rr_ptr <= ptr_nxt;
      end
    end
  end

endmodule
